// File: rtl/memory_access.sv
// rtl/memory_access.sv - Y86-64 memory stage with internal byte-addressed little-endian data RAM
module memory_access #(
    parameter int MEM_BYTES   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_icode,
    input  logic [3:0]                   in_rA,
    input  logic [3:0]                   in_rB,
    input  logic [2:0]                   in_stat,
    input  logic [63:0]                  in_valA,
    input  logic [63:0]                  in_valE,
    input  logic [63:0]                  in_valP,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   out_icode,
    output logic [3:0]                   out_rA,
    output logic [3:0]                   out_rB,
    output logic [63:0]                  out_valE,
    output logic [63:0]                  out_valM,
    output logic [2:0]                   out_stat,
    input  logic [$clog2(MEM_BYTES)-1:0] dbg_addr,
    output logic [63:0]                  dbg_data
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
    // Highest legal start address of an 8-byte access
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [1:0] HALT   = 2'd3;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    logic [7:0]    mem [MEM_BYTES];
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          cap_wr;
    logic [AW-1:0] cap_addr;
    logic [63:0]   cap_wdata;

    logic          acc_wr;
    logic          acc_rd;
    logic          acc_err;
    logic [63:0]   acc_addr;
    logic [63:0]   acc_wdata;
    logic [63:0]   rd_data;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Decode the access type, address and store data of the offered instruction
    always_comb begin
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        acc_addr  = in_valE;
        acc_wdata = in_valA;
        case (in_icode)
            4'h4, 4'hA: acc_wr = 1'b1;
            4'h8: begin
                acc_wr    = 1'b1;
                acc_wdata = in_valP;
            end
            4'h5: acc_rd = 1'b1;
            4'h9, 4'hB: begin
                acc_rd   = 1'b1;
                acc_addr = in_valA;
            end
            default: ;
        endcase
        acc_err = (acc_addr > ADDR_MAX);
    end

    // Little-endian 8-byte reads for the pending load and the debug port (debug wraps)
    always_comb begin
        rd_data  = '0;
        dbg_data = '0;
        for (int i = 0; i < 8; i++) begin
            rd_data[8*i +: 8]  = mem[cap_addr + AW'(i)];
            dbg_data[8*i +: 8] = mem[dbg_addr + AW'(i)];
        end
    end

    // Stage control: accept, count down the access latency, hold the result, halt
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            out_icode <= '0;
            out_rA    <= '0;
            out_rB    <= '0;
            out_valE  <= '0;
            out_valM  <= '0;
            out_stat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_icode <= in_icode;
                        out_rA    <= in_rA;
                        out_rB    <= in_rB;
                        out_valE  <= in_valE;
                        out_valM  <= '0;
                        if (in_stat != STAT_AOK || !(acc_wr || acc_rd)) begin
                            out_stat <= in_stat;
                            state    <= DONE;
                        end else if (acc_err) begin
                            out_stat <= STAT_ADR;
                            state    <= DONE;
                        end else begin
                            out_stat  <= STAT_AOK;
                            cap_wr    <= acc_wr;
                            cap_addr  <= acc_addr[AW-1:0];
                            cap_wdata <= acc_wdata;
                            cnt       <= CNT_INIT;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!cap_wr) begin
                            out_valM <= rd_data;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= (out_stat == STAT_AOK) ? IDLE : HALT;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // RAM store on the final access edge; reset aborts the store
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && cnt == '0 && cap_wr) begin
            for (int i = 0; i < 8; i++) begin
                mem[cap_addr + AW'(i)] <= cap_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - scoreboard testbench for memory_access
module tb_memory_access;

    localparam int MB  = 1024;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [3:0]  in_rA;
    logic [3:0]  in_rB;
    logic [2:0]  in_stat;
    logic [63:0] in_valA;
    logic [63:0] in_valE;
    logic [63:0] in_valP;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [3:0]  out_rA;
    logic [3:0]  out_rB;
    logic [63:0] out_valE;
    logic [63:0] out_valM;
    logic [2:0]  out_stat;
    logic [9:0]  dbg_addr;
    logic [63:0] dbg_data;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [2:0]  stat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    memory_access #(.MEM_BYTES(MB), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB), .in_stat(in_stat),
        .in_valA(in_valA), .in_valE(in_valE), .in_valP(in_valP),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_rA(out_rA), .out_rB(out_rB),
        .out_valE(out_valE), .out_valM(out_valM), .out_stat(out_stat),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every result transfer is matched against the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_icode", 64'(out_icode), 64'(e.icode));
                check("out_rA", 64'(out_rA), 64'(e.ra));
                check("out_rB", 64'(out_rB), 64'(e.rb));
                check("out_valE", out_valE, e.vale);
                check("out_valM", out_valM, e.valm);
                check("out_stat", 64'(out_stat), 64'(e.stat));
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one instruction and return #1 after its accept edge
    task automatic offer(input logic [3:0] ic, input logic [2:0] st,
                         input logic [63:0] va, input logic [63:0] ve, input logic [63:0] vp);
        int n;
        in_icode = ic; in_rA = ic ^ 4'h3; in_rB = ic ^ 4'h5; in_stat = st;
        in_valA = va; in_valE = ve; in_valP = vp;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step(1);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] ic, input logic [2:0] st,
                        input logic [63:0] va, input logic [63:0] ve, input logic [63:0] vp,
                        input logic [63:0] exp_m, input logic [2:0] exp_st);
        exp_t e;
        e.icode = ic; e.ra = ic ^ 4'h3; e.rb = ic ^ 4'h5;
        e.vale = ve; e.valm = exp_m; e.stat = exp_st;
        exp_q.push_back(e);
        offer(ic, st, va, ve, vp);
    endtask

    task automatic edges_to_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step(1);
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        if (n >= 50) check("drain_timeout", 64'd1, 64'd0);
        step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] hold_m;
        logic [63:0] hold_e;
        in_valid = 1'b0; in_icode = '0; in_rA = '0; in_rB = '0; in_stat = '0;
        in_valA = '0; in_valE = '0; in_valP = '0; out_ready = 1'b1; dbg_addr = '0;
        reset = 1'b1;
        step(3);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_valE", out_valE, 64'd0);
        check("rst_out_stat", 64'(out_stat), 64'd0);
        reset = 1'b0;
        step(1);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // rmmovq store and its latency
        send(4'h4, 3'd1, 64'h1122334455667788, 64'h10, 64'h0, 64'h0, 3'd1);
        edges_to_valid(n);
        check("store_latency", 64'(n), 64'(LAT));
        drain();
        dbg_addr = 10'h010; #1;
        check("dbg_store", dbg_data, 64'h1122334455667788);
        check("dbg_byte0", 64'(dbg_data[7:0]), 64'h88);
        dbg_addr = 10'h011; #1;
        check("dbg_byte1", 64'(dbg_data[7:0]), 64'h77);

        // mrmovq load
        send(4'h5, 3'd1, 64'h0, 64'h10, 64'h0, 64'h1122334455667788, 3'd1);
        edges_to_valid(n);
        check("load_latency", 64'(n), 64'(LAT));
        drain();

        // call / ret at the top of memory
        send(4'h8, 3'd1, 64'h0, 64'h3F8, 64'h42, 64'h0, 3'd1);
        drain();
        dbg_addr = 10'h3F8; #1;
        check("dbg_call", dbg_data, 64'h42);
        send(4'h9, 3'd1, 64'h3F8, 64'h400, 64'h0, 64'h42, 3'd1);
        drain();

        // no-access instruction is ready right after accept
        send(4'h6, 3'd1, 64'h5, 64'hDEAD, 64'h0, 64'h0, 3'd1);
        check("noacc_valid", 64'(out_valid), 64'd1);
        drain();

        // backpressure in DONE
        out_ready = 1'b0;
        send(4'h5, 3'd1, 64'h0, 64'h10, 64'h0, 64'h1122334455667788, 3'd1);
        edges_to_valid(n);
        hold_m = out_valM;
        hold_e = out_valE;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_valM", out_valM, hold_m);
            check("bp_valE", out_valE, hold_e);
        end
        out_ready = 1'b1;
        step(1);
        check("bp_released", 64'(out_valid), 64'd0);
        check("bp_idle", 64'(in_ready), 64'd1);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // pushq aborted by reset in its first ACCESS cycle
        send(4'h4, 3'd1, 64'h0102030405060708, 64'h100, 64'h0, 64'h0, 3'd1);
        drain();
        offer(4'hA, 3'd1, 64'hCAFEF00DCAFEF00D, 64'h100, 64'h0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        step(3);
        dbg_addr = 10'h100; #1;
        check("abort_ram", dbg_data, 64'h0102030405060708);

        // last legal address, then an address error that halts the stage
        send(4'h5, 3'd1, 64'h0, 64'(MB - 8), 64'h0, 64'h42, 3'd1);
        drain();
        send(4'h5, 3'd1, 64'h0, 64'(MB - 7), 64'h0, 64'h0, 3'd3);
        drain();
        step(3);
        check("halt_in_ready", 64'(in_ready), 64'd0);
        check("halt_out_valid", 64'(out_valid), 64'd0);

        // full-width address compare and popq error through valA
        do_reset();
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        send(4'h5, 3'd1, 64'h0, 64'h1_0000_0010, 64'h0, 64'h0, 3'd3);
        drain();
        do_reset();
        send(4'hB, 3'd1, 64'h400, 64'h10, 64'h0, 64'h0, 3'd3);
        drain();

        // HLT status with rmmovq: no store, status forwarded, then halt
        do_reset();
        send(4'h4, 3'd1, 64'h5555AAAA5555AAAA, 64'h200, 64'h0, 64'h0, 3'd1);
        drain();
        send(4'h4, 3'd2, 64'hBEEF, 64'h200, 64'h0, 64'h0, 3'd2);
        drain();
        dbg_addr = 10'h200; #1;
        check("hlt_no_write", dbg_data, 64'h5555AAAA5555AAAA);
        step(2);
        check("hlt_halt", 64'(in_ready), 64'd0);

        // debug read wraps modulo the memory size
        dbg_addr = 10'h3FC; #1;
        check("dbg_wrap_lo", 64'(dbg_data[7:0]), 64'h00);
        dbg_addr = 10'h3F8; #1;
        check("dbg_wrap_ref", 64'(dbg_data[7:0]), 64'h42);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
